adder_arbiter: RTL and testbench
================================

ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter WIDTH, default 8: operand and sum width in bits; legal range 1 to 32.
REQ-002 Parameter NREQ, default 4: number of requesters sharing the adder; legal range 2 to 8.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous and active-low.
REQ-005 req_valid  input  NREQ  per-requester operand valid.
REQ-006 req_ready  output  NREQ  per-requester accept; at most one bit high per cycle.
REQ-007 req_a  input  NREQ*WIDTH  packed operand A; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-008 req_b  input  NREQ*WIDTH  packed operand B, same packing as req_a.
REQ-009 rsp_valid  output  1  result valid.
REQ-010 rsp_ready  input  1  result consumer accept.
REQ-011 rsp_id  output  clog2(NREQ)  index of the requester that owns the result.
REQ-012 rsp_sum  output  WIDTH  registered sum.
REQ-013 rsp_carry  output  1  registered carry-out of the WIDTH-bit addition.

Function
REQ-014 Transfers: request i transfers when req_valid[i] and req_ready[i] are both high at a rising edge; the response transfers when rsp_valid and rsp_ready are both high at a rising edge.
REQ-015 States: IDLE (output buffer empty) and HOLD (result held).
REQ-016 IDLE->HOLD on a request transfer.
REQ-017 HOLD->IDLE on a response transfer with no simultaneous request transfer.
REQ-018 HOLD->HOLD on a simultaneous response transfer and request transfer, or when rsp_ready is low.
REQ-019 req_ready is combinational: the grant bit of the round-robin arbiter, qualified by (state==IDLE) or (rsp_ready high); it is never high for a requester whose req_valid is low.
REQ-020 Round-robin arbitration: search starts at pointer ptr and ascends modulo NREQ; the first requester with req_valid high wins.
REQ-021 After each request transfer, ptr becomes (granted index + 1) mod NREQ; ptr is unchanged in cycles with no transfer.
REQ-022 Latency: one cycle; a request transferring at edge N gives rsp_valid high from edge N onward, with rsp_sum, rsp_carry and rsp_id registered at edge N.
REQ-023 Arithmetic: {rsp_carry, rsp_sum} = zero-extended a + zero-extended b, computed WIDTH+1 bits wide.
REQ-024 rsp_sum, rsp_carry and rsp_id stay stable while rsp_valid is high and rsp_ready is low.
REQ-025 Back-to-back throughput: one result per cycle while rsp_ready is held high.
REQ-026 A requester that drops req_valid before it is granted is not served, and no state changes on its account.

Reset
REQ-027 While rst_n is low: state=IDLE, ptr=0, rsp_valid=0, rsp_sum=0, rsp_carry=0, rsp_id=0, req_ready all 0.
REQ-028 Reset asserted mid-operation discards any held result without a response transfer.
REQ-029 Arbitration resumes on the first rising edge after rst_n deasserts.

Configuration
REQ-030 Macro ADDER_ARBITER_SATURATE_EN, defined: when the carry is 1, rsp_sum is all-ones; rsp_carry still reports the true carry.
REQ-031 Macro ADDER_ARBITER_SATURATE_EN, undefined: rsp_sum wraps modulo 2^WIDTH; no saturation logic is present.

Structure
REQ-032 Shared package adder_arbiter_pkg holds the state encoding constants (IDLE=0, HOLD=1) and the ID-width function clog2.
REQ-033 One sub-module, rr_arbiter: parameter N; inputs req[N] and ptr; outputs one-hot gnt[N] and gnt_idx; purely combinational.
REQ-034 Total RTL size is 120 to 400 lines.

Verification (WIDTH=8, NREQ=4)
REQ-035 Single request: req_valid=0001, a0=0x12, b0=0x34, rsp_ready=1 -> one cycle later rsp_valid=1, rsp_sum=0x46, rsp_carry=0, rsp_id=0.
REQ-036 Carry: a=0xF0, b=0x20 -> rsp_carry=1; rsp_sum=0x10 without the macro, 0xFF with it.
REQ-037 Fairness: req_valid=1111 held, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0 on consecutive cycles; every requester is served exactly once per 4 cycles.
REQ-038 Backpressure: rsp_ready=0 for 3 cycles with a result held -> req_ready=0000, rsp outputs stable; rsp_ready=1 -> response transfers and the next grant occurs in the same cycle.
REQ-039 Reset mid-HOLD: rst_n=0 while rsp_valid=1 -> rsp_valid=0 immediately (asynchronously); after release, req_valid=0100 -> rsp_id=2, since ptr was reset to 0.

Source files
------------

// File: rtl/adder_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// adder_arbiter_pkg
// Shared definitions for the adder_arbiter block:
//   - state_e : two-state output-buffer encoding (IDLE = 0, HOLD = 1)
//   - clog2   : ceiling log2, used to size requester indices
// -----------------------------------------------------------------------------
package adder_arbiter_pkg;

    // IDLE: output buffer empty.  HOLD: a result is held for the consumer.
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    // Ceiling log2.  Only ever called with n >= 2 here, so the result is >= 1
    // and index vectors never collapse to zero width.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage : adder_arbiter_pkg

// File: rtl/adder_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter.  The search starts at ptr and
// ascends modulo N; the first asserted request wins.
//
// Ports
//   req     in   N      request vector
//   ptr     in   IW     starting index of the search (must be < N)
//   gnt     out  N      one-hot grant (all zero when no request)
//   gnt_idx out  IW     binary index of the granted requester (0 when none)
// -----------------------------------------------------------------------------
module rr_arbiter
    import adder_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    // One extra bit so ptr + k (both < N) cannot overflow before the wrap.
    localparam logic [IW:0] N_W = (IW + 1)'(N);

    logic          found;
    logic [IW:0]   cand_sum;
    logic [IW-1:0] cand_idx;

    always_comb begin
        gnt      = '0;
        gnt_idx  = '0;
        found    = 1'b0;
        cand_sum = '0;
        cand_idx = '0;
        for (int k = 0; k < N; k++) begin
            // Rotated index: (ptr + k) mod N with a single conditional
            // subtraction, valid because ptr + k < 2N.
            cand_sum = {1'b0, ptr} + (IW + 1)'(k);
            if (cand_sum >= N_W) begin
                cand_sum = cand_sum - N_W;
            end
            cand_idx = cand_sum[IW-1:0];
            if (!found && req[cand_idx]) begin
                found         = 1'b1;
                gnt[cand_idx] = 1'b1;
                gnt_idx       = cand_idx;
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/adder_arbiter.sv
// -----------------------------------------------------------------------------
// adder_arbiter
// NREQ requesters share one WIDTH-bit adder.  A round-robin arbiter picks one
// valid requester per cycle; its operands are added and the result is held in
// a one-entry output register until the consumer accepts it.  A new request
// may be accepted in the same cycle the held result leaves, giving one result
// per cycle while rsp_ready stays high.
//
// Ports
//   clk        in   1            clock, rising edge
//   rst_n      in   1            asynchronous active-low reset
//   req_valid  in   NREQ         per-requester operand valid
//   req_ready  out  NREQ         per-requester accept (at most one bit high)
//   req_a      in   NREQ*WIDTH   packed operand A, requester i at [i*WIDTH +: WIDTH]
//   req_b      in   NREQ*WIDTH   packed operand B, same packing
//   rsp_valid  out  1            result valid
//   rsp_ready  in   1            result accept
//   rsp_id     out  clog2(NREQ)  requester owning the result
//   rsp_sum    out  WIDTH        registered sum
//   rsp_carry  out  1            registered carry-out
//
// Build option
//   ADDER_ARBITER_SATURATE_EN : when defined, rsp_sum saturates to all-ones on
//   carry-out (rsp_carry still reports the true carry).  When undefined the
//   sum wraps modulo 2^WIDTH.
// -----------------------------------------------------------------------------
module adder_arbiter
    import adder_arbiter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*WIDTH-1:0]     req_a,
    input  logic [NREQ*WIDTH-1:0]     req_b,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [clog2(NREQ)-1:0]    rsp_id,
    output logic [WIDTH-1:0]          rsp_sum,
    output logic                      rsp_carry
);

    localparam int            IW       = clog2(NREQ);
    localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e          state_q, state_d;
    logic [IW-1:0]   ptr_q,   ptr_d;
    logic [WIDTH-1:0] sum_q,  sum_d;
    logic            carry_q, carry_d;
    logic [IW-1:0]   id_q,    id_d;

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
    logic [NREQ-1:0] gnt;
    logic [IW-1:0]   gnt_idx;

    rr_arbiter #(
        .N  (NREQ),
        .IW (IW)
    ) u_rr_arbiter (
        .req     (req_valid),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    logic can_accept;
    logic req_fire;
    logic rsp_fire;

    // A slot is free when the buffer is empty or the held result is leaving
    // this cycle.  rst_n gates the grant so nothing is offered during reset.
    assign can_accept = rst_n && ((state_q == IDLE) || rsp_ready);
    assign req_ready  = can_accept ? gnt : '0;
    // gnt is only ever set for valid requesters, so any ready bit is a transfer.
    assign req_fire   = |req_ready;

    assign rsp_valid  = (state_q == HOLD);
    assign rsp_fire   = rsp_valid && rsp_ready;

    // -------------------------------------------------------------------------
    // Operand select and add
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;
    logic [WIDTH:0]   sum_full;
    logic [WIDTH-1:0] sum_res;

    // AND-OR mux on the one-hot grant: no index arithmetic on the packed bus.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                a_sel = a_sel | req_a[i*WIDTH +: WIDTH];
                b_sel = b_sel | req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    assign sum_full = {1'b0, a_sel} + {1'b0, b_sel};

`ifdef ADDER_ARBITER_SATURATE_EN
    assign sum_res = sum_full[WIDTH] ? {WIDTH{1'b1}} : sum_full[WIDTH-1:0];
`else
    assign sum_res = sum_full[WIDTH-1:0];
`endif

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        id_d    = id_q;

        case (state_q)
            IDLE: begin
                if (req_fire) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // A request can only fire in HOLD when rsp_ready is high,
                // i.e. alongside a response transfer, so the buffer refills.
                if (rsp_fire && !req_fire) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (req_fire) begin
            sum_d   = sum_res;
            carry_d = sum_full[WIDTH];
            id_d    = gnt_idx;
            ptr_d   = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            id_q    <= id_d;
        end
    end

    assign rsp_sum   = sum_q;
    assign rsp_carry = carry_q;
    assign rsp_id    = id_q;

endmodule : adder_arbiter

// File: tb/tb_adder_arbiter.sv
// -----------------------------------------------------------------------------
// tb_adder_arbiter
// Directed-vector bench for adder_arbiter (WIDTH=8, NREQ=4).  Stimulus pushes
// hand-computed expected responses into a queue; a monitor pops and compares
// whenever a response transfer is about to happen.
// -----------------------------------------------------------------------------
module tb_adder_arbiter;

    localparam int WIDTH = 8;
    localparam int NREQ  = 4;

`ifdef ADDER_ARBITER_SATURATE_EN
    localparam logic [7:0] SUM_F0_20 = 8'hFF;
    localparam logic [7:0] SUM_FF_FF = 8'hFF;
`else
    localparam logic [7:0] SUM_F0_20 = 8'h10;
    localparam logic [7:0] SUM_FF_FF = 8'hFE;
`endif

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [1:0]            rsp_id;
    logic [WIDTH-1:0]      rsp_sum;
    logic                  rsp_carry;

    adder_arbiter #(
        .WIDTH (WIDTH),
        .NREQ  (NREQ)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_carry (rsp_carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] sum;
        logic       carry;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [1:0] id, input logic [7:0] sum, input logic carry);
        exp_t e;
        e.id    = id;
        e.sum   = sum;
        e.carry = carry;
        sb_q.push_back(e);
    endtask

    task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
        req_a[i*WIDTH +: WIDTH] = a;
        req_b[i*WIDTH +: WIDTH] = b;
    endtask

    // Offer one request from requester idx for one cycle.
    task automatic single(input int idx, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] exp_sum, input logic exp_carry);
        logic [3:0] onehot;
        onehot = 4'b0001 << idx;
        @(posedge clk); #1;
        set_ops(idx, a, b);
        req_valid = onehot;
        push_exp(2'(idx), exp_sum, exp_carry);
        @(negedge clk);
        check($sformatf("single%0d_ready", idx), 32'(req_ready), 32'(onehot));
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        check($sformatf("single%0d_latency", idx), 32'(rsp_valid), 32'd1);
    endtask

    task automatic drain();
        for (int c = 0; c < 20; c++) begin
            if (sb_q.size() == 0) break;
            @(negedge clk);
            #1;
        end
        check("drain", 32'(sb_q.size()), 32'd0);
    endtask

    // Monitor: a response transfers at the next rising edge whenever
    // rsp_valid && rsp_ready are high mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && rsp_valid && rsp_ready) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_rsp: got id=%0d sum=%0h carry=%0d expected none",
                             rsp_id, rsp_sum, rsp_carry);
                end else begin
                    e = sb_q.pop_front();
                    n_cmp++;
                    if (rsp_id !== e.id || rsp_sum !== e.sum || rsp_carry !== e.carry) begin
                        n_err++;
                        $display("FAIL rsp: got id=%0d sum=%0h carry=%0d expected id=%0d sum=%0h carry=%0d",
                                 rsp_id, rsp_sum, rsp_carry, e.id, e.sum, e.carry);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        req_a     = '0;
        req_b     = '0;

        // Reset state, with requests pending to prove nothing is offered.
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_sum",   32'(rsp_sum),   32'd0);
        check("rst_carry", 32'(rsp_carry), 32'd0);
        check("rst_id",    32'(rsp_id),    32'd0);
        req_valid = '0;
        @(posedge clk); #2;
        rst_n     = 1'b1;
        rsp_ready = 1'b1;

        // Single requests; order chosen so ptr returns to 0 afterwards.
        single(0, 8'h12, 8'h34, 8'h46, 1'b0);
        single(1, 8'hF0, 8'h20, SUM_F0_20, 1'b1);
        single(2, 8'h00, 8'h00, 8'h00, 1'b0);
        single(3, 8'hFF, 8'hFF, SUM_FF_FF, 1'b1);
        drain();

        // Fairness: all valid, rsp_ready high -> ids 0,1,2,3,0.
        set_ops(0, 8'h10, 8'h00);
        set_ops(1, 8'h20, 8'h01);
        set_ops(2, 8'h30, 8'h02);
        set_ops(3, 8'h40, 8'h03);
        @(posedge clk); #1;
        req_valid = 4'b1111;
        push_exp(2'd0, 8'h10, 1'b0);
        push_exp(2'd1, 8'h21, 1'b0);
        push_exp(2'd2, 8'h32, 1'b0);
        push_exp(2'd3, 8'h43, 1'b0);
        push_exp(2'd0, 8'h10, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("fair_ready%0d", k), 32'(req_ready), 32'(4'b0001 << (k % 4)));
            @(posedge clk);
        end
        #1;
        req_valid = '0;
        drain();

        // Backpressure (ptr = 1): requester 2 alone, then hold with all valid.
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_valid = 4'b0100;
        push_exp(2'd2, 8'h32, 1'b0);
        @(negedge clk);
        check("bp_first_ready", 32'(req_ready), 32'b0100);
        @(posedge clk); #1;
        req_valid = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("bp_ready%0d", k), 32'(req_ready), 32'd0);
            check($sformatf("bp_hold%0d", k),
                  {21'd0, rsp_valid, rsp_id, rsp_sum, rsp_carry},
                  {21'd0, 1'b1, 2'd2, 8'h32, 1'b0});
            @(posedge clk);
        end
        #1;
        rsp_ready = 1'b1;
        push_exp(2'd3, 8'h43, 1'b0);
        @(negedge clk);
        check("bp_release_ready", 32'(req_ready), 32'b1000);
        @(posedge clk); #1;
        req_valid = '0;
        drain();

        // Reset mid-HOLD (ptr = 0): requester 1 held, then async reset.
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_valid = 4'b0010;
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        check("hold_before_rst", {30'd0, rsp_valid, 1'b0} | 32'(rsp_id), 32'b11);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(rsp_valid), 32'd0);
        check("async_rst_id",    32'(rsp_id),    32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;

        // ptr must be 0 again: 0101 grants requester 0, not 2.
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        req_valid = 4'b0101;
        push_exp(2'd0, 8'h10, 1'b0);
        @(negedge clk);
        check("post_rst_ready", 32'(req_ready), 32'b0001);
        @(posedge clk); #1;
        req_valid = '0;
        drain();

        single(2, 8'h30, 8'h02, 8'h32, 1'b0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule : tb_adder_arbiter
